// File: rtl/prescaled_updown_counter.sv
// Up/down counter advanced by an internal prescaler clock enable. Everything runs in one clock domain.
// The counter supports synchronous load (clamped to MAX), wrap or saturate at its limits, and a terminal-count pulse.
module prescaled_updown_counter #(
    parameter int WIDTH = 4,
    parameter int N     = 20,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [N-1:0]     prescaler;
    logic             step;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_data;
    logic             next_tc;

    // The prescaler is all ones exactly when it is about to roll over.
    assign step         = en && (&prescaler);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_data = data;
        next_tc   = 1'b0;
        if (load) begin
            next_data = load_clamped;
        end else if (step) begin
            if (dir) begin
                if (data < MAX_V) begin
                    next_data = data + WIDTH'(1);
                end else begin
                    next_data = sat ? MAX_V : '0;
                    next_tc   = 1'b1;
                end
            end else begin
                if (data != '0) begin
                    next_data = data - WIDTH'(1);
                end else begin
                    next_data = sat ? '0 : MAX_V;
                    next_tc   = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            data      <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            if (en) begin
                prescaler <= prescaler + N'(1);
            end
            tick <= step;
            data <= next_data;
            tc   <= next_tc;
        end
    end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter with N=2, WIDTH=4 and MAX=9.
// Expected values are worked out by hand from the intended prescaler and counter timing.
module tb_prescaled_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic       sat;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] data;
    logic       tick;
    logic       tc;

    int checks   = 0;
    int failures = 0;

    prescaled_updown_counter #(.WIDTH(4), .N(2), .MAX(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .data     (data),
        .tick     (tick),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Advance n clocks; inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0; load_val = 4'd0;

        // Reset phase.
        clocks(2);
        check("rst_data", 32'(data), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_tc",   32'(tc),   32'd0);

        // The first step fires on the 4th enabled edge.
        rst = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b0;
        clocks(3);
        check("pre_step_data", 32'(data), 32'd0);
        check("pre_step_tick", 32'(tick), 32'd0);
        clocks(1);
        check("step1_data", 32'(data), 32'd1);
        check("step1_tick", 32'(tick), 32'd1);
        check("step1_tc",   32'(tc),   32'd0);

        // Count up through MAX.
        for (int k = 2; k <= 9; k++) begin
            clocks(1);
            check("up_tick_low", 32'(tick), 32'd0);
            check("up_hold",     32'(data), 32'(k - 1));
            clocks(3);
            check("up_data", 32'(data), 32'(k));
            check("up_tick", 32'(tick), 32'd1);
            check("up_tc",   32'(tc),   32'd0);
        end

        // The 10th step wraps to 0 and raises tc for one cycle.
        clocks(4);
        check("wrap_data", 32'(data), 32'd0);
        check("wrap_tc",   32'(tc),   32'd1);
        clocks(1);
        check("wrap_tc_low", 32'(tc),   32'd0);
        check("wrap_hold",   32'(data), 32'd0);

        // Saturating down count at 0; the prescaler is at 1 here.
        sat = 1'b1; dir = 1'b0; load_val = 4'd0;
        clocks(3);
        check("satdn1_data", 32'(data), 32'd0);
        check("satdn1_tc",   32'(tc),   32'd1);
        clocks(1);
        check("satdn1_tc_low", 32'(tc), 32'd0);
        clocks(3);
        check("satdn2_data", 32'(data), 32'd0);
        check("satdn2_tc",   32'(tc),   32'd1);
        clocks(1);

        // A load on a step edge is clamped to MAX and drops the step.
        clocks(2);
        load = 1'b1; load_val = 4'd13;
        clocks(1);
        load = 1'b0;
        check("load_clamp_data", 32'(data), 32'd9);
        check("load_clamp_tc",   32'(tc),   32'd0);
        check("load_clamp_tick", 32'(tick), 32'd1);

        // A mid-interval disable freezes the prescaler and the counter.
        clocks(2);
        en = 1'b0;
        clocks(7);
        check("frozen_data", 32'(data), 32'd9);
        check("frozen_tick", 32'(tick), 32'd0);
        en = 1'b1;
        clocks(1);
        check("resume_hold", 32'(data), 32'd9);
        check("resume_tick_low", 32'(tick), 32'd0);
        clocks(1);
        check("resume_step_data", 32'(data), 32'd8);
        check("resume_step_tick", 32'(tick), 32'd1);

        // A load is honoured while disabled.
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        clocks(1);
        load = 1'b0;
        check("load_dis_data", 32'(data), 32'd0);

        // Down count wraps from 0 to MAX.
        en = 1'b1; sat = 1'b0; dir = 1'b0;
        clocks(3);
        check("wrapdn_hold", 32'(data), 32'd0);
        clocks(1);
        check("wrapdn_data", 32'(data), 32'd9);
        check("wrapdn_tc",   32'(tc),   32'd1);

        // Up count saturates at MAX.
        sat = 1'b1; dir = 1'b1;
        clocks(4);
        check("satup_data", 32'(data), 32'd9);
        check("satup_tc",   32'(tc),   32'd1);

        // Reset while data=7 and the prescaler=3.
        load = 1'b1; load_val = 4'd7;
        clocks(1);
        load = 1'b0;
        check("load7_data", 32'(data), 32'd7);
        clocks(2);
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        check("midrst_tc",   32'(tc),   32'd0);
        clocks(3);
        check("post_rst_hold", 32'(data), 32'd0);
        clocks(1);
        check("post_rst_step", 32'(data), 32'd1);
        check("post_rst_tick", 32'(tick), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
